rc_req_buf: RTL

- Entry buffer for the ring controller. It accepts core/ring transactions, stores each one in a free entry, and drives the allocation and deallocation interface of the downstream ordering matrix (mro).
- It uses the matrix's two oldest-entry selections to issue transactions in age order on two output channels:
  - RSP channel: read responses.
  - REQ channel: read and write requests.
- It sits between the core/ring ingress and the ring egress arbiter.

---
 rtl/rc_pkg.sv | 29 ++
 rtl/rc_req_entry.sv | 53 +++++
 rtl/rc_req_buf.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rc_pkg.sv
// Shared types for the ring-controller entry buffer.
// Opcode encoding, entry state encoding and default sizing constants.
// No logic; imported by rc_req_entry and rc_req_buf.
package rc_pkg;

  localparam int RC_NUM_ENTRIES = 4;
  localparam int RC_ADDR_W      = 32;
  localparam int RC_DATA_W      = 32;

  typedef enum logic [1:0] {
    RC_RD_REQ = 2'd0,
    RC_WR_REQ = 2'd1,
    RC_RD_RSP = 2'd2,
    RC_RSVD   = 2'd3
  } t_rc_opcode;

  typedef enum logic {
    RC_FREE = 1'b0,
    RC_PEND = 1'b1
  } t_rc_state;

  // Default-width view of one stored transaction.
  typedef struct packed {
    t_rc_opcode           opcode;
    logic [RC_ADDR_W-1:0] addr;
    logic [RC_DATA_W-1:0] data;
  } t_rc_entry;

endpackage

// File: rtl/rc_req_entry.sv
// One buffer entry: FREE/PEND state flop plus opcode/address/data payload.
// Ports: Clk/Rst, alloc+payload in (loads and goes PEND), dealloc in
// (returns to FREE), pend/opcode/addr/data out, all from registered state.
module rc_req_entry
  import rc_pkg::*;
#(
  parameter int ADDR_W = RC_ADDR_W,
  parameter int DATA_W = RC_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              alloc,
  input  logic              dealloc,
  input  logic [1:0]        in_opcode,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              pend,
  output logic [1:0]        opcode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  t_rc_state state, state_nxt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= RC_FREE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RC_FREE: if (alloc)   state_nxt = RC_PEND;
      RC_PEND: if (dealloc) state_nxt = RC_FREE;
      default: state_nxt = RC_FREE;
    endcase
  end

  assign pend = (state == RC_PEND);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      opcode <= '0;
      addr   <= '0;
      data   <= '0;
    end else if (alloc) begin
      opcode <= in_opcode;
      addr   <= in_addr;
      data   <= in_data;
    end
  end

endmodule

// File: rtl/rc_req_buf.sv
// Ring-controller entry buffer: allocates ingress transactions into free
// entries, drives the mro alloc/dealloc/mask interface and issues the mro's
// oldest RSP / REQ entries on two valid-ready channels (zero-latency from Oldest*).
module rc_req_buf
  import rc_pkg::*;
#(
  parameter int NUM_ENTRIES = RC_NUM_ENTRIES,
  parameter int ADDR_W      = RC_ADDR_W,
  parameter int DATA_W      = RC_DATA_W,
  localparam int CW         = $clog2(NUM_ENTRIES) + 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [1:0]             InOpcode,
  input  logic [ADDR_W-1:0]      InAddr,
  input  logic [DATA_W-1:0]      InData,
  output logic                   EnAlloc,
  output logic [NUM_ENTRIES-1:0] NextAlloc,
  output logic [NUM_ENTRIES-1:0] Dealloc,
  output logic [NUM_ENTRIES-1:0] Mask0,
  output logic [NUM_ENTRIES-1:0] Mask1,
  input  logic [NUM_ENTRIES-1:0] Oldest0,
  input  logic [NUM_ENTRIES-1:0] Oldest1,
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic [ADDR_W-1:0]      RspAddr,
  output logic [DATA_W-1:0]      RspData,
  output logic                   ReqValid,
  input  logic                   ReqReady,
  output logic [1:0]             ReqOpcode,
  output logic [ADDR_W-1:0]      ReqAddr,
  output logic [DATA_W-1:0]      ReqData,
  output logic [CW-1:0]          Count
);

  logic [NUM_ENTRIES-1:0] pend_vec;
  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] target;
  logic [NUM_ENTRIES-1:0] sel0, sel1;
  logic [1:0]             ent_op   [NUM_ENTRIES];
  logic [ADDR_W-1:0]      ent_addr [NUM_ENTRIES];
  logic [DATA_W-1:0]      ent_data [NUM_ENTRIES];
  logic                   alloc_fire, rsp_fire, req_fire;
  logic [CW-1:0]          dealloc_cnt;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
    rc_req_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_entry (
      .Clk       (Clk),
      .Rst       (Rst),
      .alloc     (NextAlloc[i]),
      .dealloc   (Dealloc[i]),
      .in_opcode (InOpcode),
      .in_addr   (InAddr),
      .in_data   (InData),
      .pend      (pend_vec[i]),
      .opcode    (ent_op[i]),
      .addr      (ent_addr[i]),
      .data      (ent_data[i])
    );
    // Reserved opcode lands in neither mask, so it can never be issued.
    assign Mask0[i] = pend_vec[i] && (ent_op[i] == RC_RD_RSP);
    assign Mask1[i] = pend_vec[i] && ((ent_op[i] == RC_RD_REQ) || (ent_op[i] == RC_WR_REQ));
  end

  // Allocation looks only at registered state, so an entry freed this
  // cycle cannot be handed out again until the next one.
  assign free_vec   = ~pend_vec;
  assign InReady    = |free_vec;
  assign alloc_fire = InValid & InReady;
  assign EnAlloc    = alloc_fire;

  always_comb begin
    target = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (free_vec[i]) target = NUM_ENTRIES'(1) << i;
  end

  assign NextAlloc = alloc_fire ? target : '0;

  // Gate the mro selections with our masks so stale/empty selections never
  // produce a valid.
  assign sel0     = Oldest0 & Mask0;
  assign sel1     = Oldest1 & Mask1;
  assign RspValid = |sel0;
  assign ReqValid = |sel1;
  assign rsp_fire = RspValid & RspReady;
  assign req_fire = ReqValid & ReqReady;
  assign Dealloc  = (sel0 & {NUM_ENTRIES{rsp_fire}}) | (sel1 & {NUM_ENTRIES{req_fire}});

  always_comb begin
    RspAddr   = '0;
    RspData   = '0;
    ReqOpcode = '0;
    ReqAddr   = '0;
    ReqData   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel0[i]) begin
        RspAddr = RspAddr | ent_addr[i];
        RspData = RspData | ent_data[i];
      end
      if (sel1[i]) begin
        ReqOpcode = ReqOpcode | ent_op[i];
        ReqAddr   = ReqAddr   | ent_addr[i];
        ReqData   = ReqData   | ent_data[i];
      end
    end
  end

  always_comb begin
    dealloc_cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      dealloc_cnt = dealloc_cnt + CW'(Dealloc[i]);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) Count <= '0;
    else     Count <= Count + CW'(alloc_fire) - dealloc_cnt;
  end

  a_no_realloc_freed: assert property (@(posedge Clk) disable iff (Rst)
    (NextAlloc & Dealloc) == '0);
  a_count_max: assert property (@(posedge Clk) disable iff (Rst)
    Count <= CW'(NUM_ENTRIES));
  a_count_underflow: assert property (@(posedge Clk) disable iff (Rst)
    dealloc_cnt <= Count);
  a_no_rsvd_opcode: assert property (@(posedge Clk) disable iff (Rst)
    !(alloc_fire && (InOpcode == RC_RSVD)));

endmodule
